counter_scheduler: RTL and testbench
====================================

Name: counter_scheduler

Overview:
Shares one Size-bit up-counter (timer) among NumReq requesters.
Each requester asks for a delay of limit+1 clock cycles. The block round-robin arbitrates, grants the counter to one requester, runs it from 0 to limit, then pulses done to that requester.
It sits in front of the counter datapath and replaces per-client counters. It is driven from the Ruby-VPI bench once per clock.

Parameters:
Size, 5, counter and limit width in bits
NumReq, 4, number of requesters (2..8)

Ports:
clock  input  1  system clock, all state on posedge
reset  input  1  asynchronous, active-high; clears all state immediately
req  input  NumReq  level request per requester; must stay high until its done pulse, and dropping it early aborts
req_limit  input  NumReq*Size  limit for requester i in bits [i*Size +: Size]; sampled only at grant
grant  output  NumReq  one-hot owner of the counter; all-zero when no owner
done  output  NumReq  one-cycle completion pulse to the owner
busy  output  1  high in RUN and DONE
count  output  Size  current counter value

Behaviour:
- Reset values: state=IDLE, grant=0, done=0, busy=0, count=0, limit_q=0, last=NumReq-1 (so requester 0 has top priority first).
- IDLE:
  - If req != 0, on the edge: pick the winner = first asserted index searching last+1, last+2, … modulo NumReq.
  - On that same edge: grant<=onehot(winner), limit_q<=req_limit[winner], count<=0, last<=winner, state<=RUN.
  - If req == 0, hold.
- RUN, evaluated at each edge in this priority order:
  1. req[winner]==0 → abort: grant<=0, count<=0, state<=IDLE, no done pulse.
  2. count==limit_q → grant<=0, done[winner]<=1, state<=DONE, count holds.
  3. Otherwise count<=count+1.
- DONE: one cycle. done<=0, count<=0, state<=IDLE. No arbitration in this cycle.
- Timing:
  - grant is high for exactly limit_q+1 cycles; count shows 0..limit_q during it.
  - done rises on the edge where grant falls.
  - Minimum request-to-request turnaround is 1 IDLE cycle after DONE.
  - Per-requester latency from req high in IDLE to done is limit+2 edges when uncontended.
- limit=0: grant for 1 cycle with count=0, then done.
- limit=2^Size-1: count reaches all-ones, never wraps; done follows.
- Changes to req_limit after grant are ignored (limit_q is latched).
- New req edges during RUN/DONE are queued only by their level; nothing is latched.
- After done, if the finished requester keeps req high it is re-served only after the other pending requesters, because the pointer has advanced.
- Reset asserted mid-RUN: all outputs return to reset values asynchronously. No done pulse is issued for the interrupted request.
- Invariants:
  - grant is always zero or one-hot.
  - done is always zero or one-hot.
  - grant and done are never high in the same cycle.
  - busy == (grant != 0) || (done != 0).

Decomposition:
- Shared package / include: state encoding localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2); helper function onehot(index, NumReq).
- One sub-module, rr_arbiter (parameter NumReq): combinational.
  - Inputs: req, last.
  - Outputs: any, winner index, winner one-hot.
- counter_scheduler holds the FSM, limit_q, count and last registers.

Test Plan:
1. Reset mid-RUN: req=0001, limit0=10, assert reset when count=4 → same cycle grant=0, count=0, busy=0, done=0; after release, req0 still high → regranted, count restarts at 0.
2. Single request: req=0001, limit0=3 → grant=0001 for 4 cycles with count 0,1,2,3; done=0001 one cycle; busy low one cycle later.
3. Round-robin fairness: req=1111 held, all limits=1 → grants in order 0001, 0010, 0100, 1000, 0001; each grant is 2 cycles, with DONE+IDLE gaps between grants.
4. Abort: req=0010, limit1=20; drop req1 at count=5 → next edge grant=0, count=0, no done; req=0100 pending then wins.
5. Boundaries: limit=0 → 1-cycle grant then done. limit=31 (Size=5) → count reaches 31, no wrap, done after 32 grant cycles. req_limit changed during RUN → run length unchanged.

Source files
------------

// File: rtl/counter_scheduler_pkg.sv
// Shared types and helpers for the counter scheduler: FSM encoding and
// a one-hot decode helper used by the arbiter.
package counter_scheduler_pkg;

  localparam int unsigned MaxReq = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Returns a MaxReq-wide vector with bit 'index' set; callers slice to NumReq.
  function automatic logic [MaxReq-1:0] onehot(input int unsigned index,
                                               input int unsigned num_req);
    logic [MaxReq-1:0] result;
    result = '0;
    if (index < num_req) result = MaxReq'(1) << index;
    return result;
  endfunction

endpackage

// File: rtl/counter_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: searches last+1, last+2, ... modulo
// NumReq and reports the first asserted request.
module rr_arbiter
  import counter_scheduler_pkg::*;
#(
  parameter int NumReq = 4,
  parameter int IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   last,
  output logic              any,
  output logic [IdxW-1:0]   winner_idx,
  output logic [NumReq-1:0] winner_oh
);

  logic [IdxW-1:0]   idx;
  logic [MaxReq-1:0] oh_full;

  always_comb begin
    any        = 1'b0;
    winner_idx = '0;
    idx        = '0;
    for (int off = 1; off <= NumReq; off++) begin
      idx = IdxW'((int'(last) + off) % NumReq);
      if (!any && req[idx]) begin
        any        = 1'b1;
        winner_idx = idx;
      end
    end
    oh_full   = onehot(int'(winner_idx), NumReq);
    winner_oh = any ? oh_full[NumReq-1:0] : '0;
  end

endmodule

// File: rtl/counter_scheduler.sv
// Time-shares one Size-bit up-counter among NumReq requesters: arbitrate,
// count 0..limit for the winner, then pulse done to it.
module counter_scheduler
  import counter_scheduler_pkg::*;
#(
  parameter int Size   = 5,
  parameter int NumReq = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NumReq-1:0]      req,
  input  logic [NumReq*Size-1:0] req_limit,
  output logic [NumReq-1:0]      grant,
  output logic [NumReq-1:0]      done,
  output logic                   busy,
  output logic [Size-1:0]        count,
  output logic [1:0]             state_dbg
);

  localparam int IdxW = $clog2(NumReq);

  // Handshake: req[i] is a level held high until done[i] pulses; grant[i]
  // marks ownership while counting, and dropping req[i] while granted aborts
  // the run without a done pulse.

  state_e            state, state_n;
  logic [NumReq-1:0] grant_n, done_n;
  logic [Size-1:0]   count_n, limit_q, limit_n;
  logic [IdxW-1:0]   last, last_n;

  logic              arb_any;
  logic [IdxW-1:0]   arb_idx;
  logic [NumReq-1:0] arb_oh;
  logic [Size-1:0]   limits [NumReq];

  for (genvar i = 0; i < NumReq; i++) begin : g_limits
    assign limits[i] = req_limit[i*Size +: Size];
  end

  rr_arbiter #(.NumReq(NumReq), .IdxW(IdxW)) u_arb (
    .req       (req),
    .last      (last),
    .any       (arb_any),
    .winner_idx(arb_idx),
    .winner_oh (arb_oh)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      grant   <= '0;
      done    <= '0;
      count   <= '0;
      limit_q <= '0;
      last    <= IdxW'(NumReq - 1);
    end else begin
      state   <= state_n;
      grant   <= grant_n;
      done    <= done_n;
      count   <= count_n;
      limit_q <= limit_n;
      last    <= last_n;
    end
  end

  // While granted, 'last' holds the current owner's index.
  always_comb begin
    state_n = state;
    grant_n = grant;
    done_n  = '0;
    count_n = count;
    limit_n = limit_q;
    last_n  = last;
    case (state)
      IDLE: begin
        if (arb_any) begin
          grant_n = arb_oh;
          limit_n = limits[arb_idx];
          count_n = '0;
          last_n  = arb_idx;
          state_n = RUN;
        end
      end
      RUN: begin
        if (!req[last]) begin
          grant_n = '0;
          count_n = '0;
          state_n = IDLE;
        end else if (count == limit_q) begin
          grant_n = '0;
          done_n  = grant;
          state_n = DONE;
        end else begin
          count_n = count + 1'b1;
        end
      end
      DONE: begin
        count_n = '0;
        state_n = IDLE;
      end
      default: begin
        grant_n = '0;
        count_n = '0;
        state_n = IDLE;
      end
    endcase
  end

  assign busy      = (state == RUN) || (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_counter_scheduler.sv
// Directed bench for counter_scheduler (Size=5, NumReq=4): reset, single
// request, round-robin order, abort, and limit boundary cases.
module tb_counter_scheduler;

  logic        clock;
  logic        reset;
  logic [3:0]  req;
  logic [19:0] req_limit;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;
  logic [4:0]  count;
  logic [1:0]  state_dbg;

  int checks = 0;
  int passed = 0;

  counter_scheduler #(.Size(5), .NumReq(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .req_limit(req_limit),
    .grant    (grant),
    .done     (done),
    .busy     (busy),
    .count    (count),
    .state_dbg(state_dbg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req       = '0;
    req_limit = '0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; req_limit = '0;
    #2;
    checks++; if ({grant, done, busy, count} !== 14'd0)
      $display("FAIL reset_outputs got g=%b d=%b b=%b c=%0d exp all zero", grant, done, busy, count);
    else passed++;
    checks++; if (state_dbg !== 2'd0) $display("FAIL reset_state got %0d exp 0", state_dbg);
    else passed++;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    req_limit[4:0] = 5'd10; req = 4'b0001;
    for (int i = 0; i < 5; i++) step();
    checks++; if ({grant, count} !== {4'b0001, 5'd4})
      $display("FAIL midrun_pre got g=%b c=%0d exp g=0001 c=4", grant, count);
    else passed++;
    reset = 1'b1;
    #1;
    checks++; if ({grant, done, busy, count} !== 14'd0)
      $display("FAIL midrun_async got g=%b d=%b b=%b c=%0d exp all zero", grant, done, busy, count);
    else passed++;
    #1;
    reset = 1'b0;
    step();
    checks++; if ({grant, count} !== {4'b0001, 5'd0})
      $display("FAIL midrun_regrant got g=%b c=%0d exp g=0001 c=0", grant, count);
    else passed++;
    req = '0;
    step();
    checks++; if ({grant, done} !== 8'd0) $display("FAIL midrun_drop got g=%b d=%b exp 0", grant, done);
    else passed++;
  endtask

  task automatic test_single();
    do_reset();
    req_limit[4:0] = 5'd3; req = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if ({grant, busy, count} !== {4'b0001, 1'b1, 5'(i)})
        $display("FAIL single_run[%0d] got g=%b b=%b c=%0d exp g=0001 b=1 c=%0d", i, grant, busy, count, i);
      else passed++;
    end
    step();
    checks++; if ({grant, done, busy, count} !== {4'b0000, 4'b0001, 1'b1, 5'd3})
      $display("FAIL single_done got g=%b d=%b b=%b c=%0d exp g=0 d=0001 b=1 c=3", grant, done, busy, count);
    else passed++;
    req = '0;
    step();
    checks++; if ({done, busy, count} !== 10'd0)
      $display("FAIL single_idle got d=%b b=%b c=%0d exp 0", done, busy, count);
    else passed++;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    do_reset();
    req_limit = {5'd1, 5'd1, 5'd1, 5'd1}; req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      step();
      checks++; if ({grant, count} !== {exp_g, 5'd0})
        $display("FAIL rr_grant[%0d] got g=%b c=%0d exp g=%b c=0", k, grant, count, exp_g);
      else passed++;
      step();
      checks++; if ({grant, count} !== {exp_g, 5'd1})
        $display("FAIL rr_count[%0d] got g=%b c=%0d exp g=%b c=1", k, grant, count, exp_g);
      else passed++;
      step();
      checks++; if ({grant, done} !== {4'b0000, exp_g})
        $display("FAIL rr_done[%0d] got g=%b d=%b exp g=0 d=%b", k, grant, done, exp_g);
      else passed++;
      if (k == 4) req = '0;
      step();
      checks++; if ({grant, done, busy} !== 9'd0)
        $display("FAIL rr_gap[%0d] got g=%b d=%b b=%b exp 0", k, grant, done, busy);
      else passed++;
    end
  endtask

  task automatic test_abort();
    do_reset();
    req_limit[9:5] = 5'd20; req_limit[14:10] = 5'd2; req = 4'b0010;
    for (int i = 0; i < 6; i++) step();
    checks++; if ({grant, count} !== {4'b0010, 5'd5})
      $display("FAIL abort_pre got g=%b c=%0d exp g=0010 c=5", grant, count);
    else passed++;
    req = 4'b0100;
    step();
    checks++; if ({grant, done, count} !== 13'd0)
      $display("FAIL abort_edge got g=%b d=%b c=%0d exp 0", grant, done, count);
    else passed++;
    step();
    checks++; if ({grant, count} !== {4'b0100, 5'd0})
      $display("FAIL abort_next got g=%b c=%0d exp g=0100 c=0", grant, count);
    else passed++;
    step(); step(); step();
    checks++; if ({grant, done} !== {4'b0000, 4'b0100})
      $display("FAIL abort_next_done got g=%b d=%b exp g=0 d=0100", grant, done);
    else passed++;
    req = '0;
    step();
  endtask

  task automatic test_boundaries();
    do_reset();
    req = 4'b0001;
    step();
    checks++; if ({grant, count} !== {4'b0001, 5'd0})
      $display("FAIL lim0_grant got g=%b c=%0d exp g=0001 c=0", grant, count);
    else passed++;
    step();
    checks++; if ({grant, done} !== {4'b0000, 4'b0001})
      $display("FAIL lim0_done got g=%b d=%b exp g=0 d=0001", grant, done);
    else passed++;
    req = '0;

    do_reset();
    req_limit[4:0] = 5'd31; req = 4'b0001;
    for (int i = 0; i < 32; i++) begin
      step();
      checks++; if ({grant, count} !== {4'b0001, 5'(i)})
        $display("FAIL lim31_run[%0d] got g=%b c=%0d exp g=0001 c=%0d", i, grant, count, i);
      else passed++;
    end
    step();
    checks++; if ({grant, done, count} !== {4'b0000, 4'b0001, 5'd31})
      $display("FAIL lim31_done got g=%b d=%b c=%0d exp g=0 d=0001 c=31", grant, done, count);
    else passed++;
    req = '0;

    do_reset();
    req_limit[4:0] = 5'd3; req = 4'b0001;
    step();
    req_limit[4:0] = 5'd10;
    step(); step(); step();
    checks++; if ({grant, count} !== {4'b0001, 5'd3})
      $display("FAIL latch_run got g=%b c=%0d exp g=0001 c=3", grant, count);
    else passed++;
    step();
    checks++; if ({grant, done} !== {4'b0000, 4'b0001})
      $display("FAIL latch_done got g=%b d=%b exp g=0 d=0001", grant, done);
    else passed++;
    req = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_reset_mid_run();
    test_single();
    test_round_robin();
    test_abort();
    test_boundaries();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
